// File: rtl/axis_pattern_generator.sv
// rtl/axis_pattern_generator.sv - AXI4-Stream video test-pattern source
// Gradient, colour bars, checkerboard and solid modes with frame-synchronous configuration.
module axis_pattern_generator #(
  parameter int H_RES      = 1024,
  parameter int V_RES      = 768,
  parameter int R_WIDTH    = 5,
  parameter int G_WIDTH    = 6,
  parameter int B_WIDTH    = 5,
  parameter int CHECK_LOG2 = 5,
  localparam int DATA_WIDTH = R_WIDTH + G_WIDTH + B_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [1:0]            mode_i,
  input  logic                  animate_i,
  input  logic [DATA_WIDTH-1:0] solid_color_i,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic [7:0]            frame_cnt_o,
  output logic                  busy_o
);

  localparam int XW    = $clog2(H_RES);
  localparam int YW    = $clog2(V_RES);
  localparam int SW    = ((XW > YW) ? XW : YW) + 1;
  localparam int BAR_W = H_RES / 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (R_WIDTH > XW) begin : g_bad_r_width
    $error("R_WIDTH must not exceed clog2(H_RES)");
  end
  if (G_WIDTH > YW) begin : g_bad_g_width
    $error("G_WIDTH must not exceed clog2(V_RES)");
  end
  if (B_WIDTH > SW) begin : g_bad_b_width
    $error("B_WIDTH must not exceed max(XW,YW)+1");
  end

  logic [0:0]            state;
  logic [1:0]            mode_q;
  logic                  anim_q;
  logic [DATA_WIDTH-1:0] solid_q;
  // Coordinates and bar counters describe the beat currently held in the output register.
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [2:0]            bar_idx_q;
  logic [XW-1:0]         bar_cnt_q;

  logic                  last_x;
  logic                  last_y;
  logic                  advance;
  logic                  frame_end;
  logic [XW-1:0]         nx;
  logic [YW-1:0]         ny;
  logic [2:0]            nidx;
  logic [XW-1:0]         ncnt;
  logic [1:0]            c_mode;
  logic                  c_anim;
  logic [DATA_WIDTH-1:0] c_solid;
  logic [7:0]            c_fc;
  logic                  chk;
  logic [DATA_WIDTH-1:0] pix;

  assign last_x    = (x_q == XW'(H_RES - 1));
  assign last_y    = (y_q == YW'(V_RES - 1));
  assign advance   = (state == ST_RUN) && (!m_axis_tvalid || m_axis_tready);
  assign frame_end = (state == ST_RUN) && m_axis_tvalid && m_axis_tready && last_x && last_y;

  always_comb begin
    nx      = x_q;
    ny      = y_q;
    nidx    = bar_idx_q;
    ncnt    = bar_cnt_q;
    c_mode  = mode_q;
    c_anim  = anim_q;
    c_solid = solid_q;
    c_fc    = frame_cnt_o;
    if (m_axis_tvalid) begin
      if (last_x) begin
        nx   = '0;
        nidx = '0;
        ncnt = '0;
        ny   = last_y ? '0 : y_q + YW'(1);
      end else begin
        nx = x_q + XW'(1);
        if (bar_idx_q != 3'd7) begin
          if (bar_cnt_q == XW'(BAR_W - 1)) begin
            nidx = bar_idx_q + 3'd1;
            ncnt = '0;
          end else begin
            ncnt = bar_cnt_q + XW'(1);
          end
        end
      end
      // The first pixel of a back-to-back frame uses the freshly sampled configuration.
      if (last_x && last_y) begin
        c_mode  = mode_i;
        c_anim  = animate_i;
        c_solid = solid_color_i;
        c_fc    = frame_cnt_o + 8'd1;
      end
    end
  end

  always_comb begin
    chk = ((((32'(nx) >> CHECK_LOG2) ^ (32'(ny) >> CHECK_LOG2)) & 32'd1) != 32'd0);
    case (c_mode)
      2'd0: pix = {R_WIDTH'(nx >> (XW - R_WIDTH)),
                   G_WIDTH'(ny >> (YW - G_WIDTH)),
                   B_WIDTH'((32'(nx) + 32'(ny) + (c_anim ? 32'(c_fc) : 32'd0)) >> (SW - B_WIDTH))};
      2'd1: pix = {{R_WIDTH{~nidx[1]}}, {G_WIDTH{~nidx[2]}}, {B_WIDTH{~nidx[0]}}};
      2'd2: pix = chk ? '0 : '1;
      default: pix = c_solid;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      mode_q        <= '0;
      anim_q        <= 1'b0;
      solid_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      bar_idx_q     <= '0;
      bar_cnt_q     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_cnt_o   <= '0;
      busy_o        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_i) begin
            state     <= ST_RUN;
            busy_o    <= 1'b1;
            mode_q    <= mode_i;
            anim_q    <= animate_i;
            solid_q   <= solid_color_i;
            x_q       <= '0;
            y_q       <= '0;
            bar_idx_q <= '0;
            bar_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          if (frame_end && !enable_i) begin
            state         <= ST_IDLE;
            busy_o        <= 1'b0;
            frame_cnt_o   <= frame_cnt_o + 8'd1;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            bar_idx_q     <= '0;
            bar_cnt_q     <= '0;
          end else if (advance) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= pix;
            m_axis_tuser  <= (nx == '0) && (ny == '0);
            m_axis_tlast  <= (nx == XW'(H_RES - 1));
            x_q           <= nx;
            y_q           <= ny;
            bar_idx_q     <= nidx;
            bar_cnt_q     <= ncnt;
            if (frame_end) begin
              frame_cnt_o <= frame_cnt_o + 8'd1;
              mode_q      <= mode_i;
              anim_q      <= animate_i;
              solid_q     <= solid_color_i;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pattern_generator.sv
// tb/tb_axis_pattern_generator.sv - randomized bench with behavioural pattern model
module tb_axis_pattern_generator;

  localparam int H     = 16;
  localparam int V     = 4;
  localparam int RW    = 4;
  localparam int GW    = 2;
  localparam int BW    = 3;
  localparam int CL    = 1;
  localparam int XW    = 4;
  localparam int YW    = 2;
  localparam int SW    = 5;
  localparam int BAR_W = H / 8;
  localparam int FRAME = H * V;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] mode;
  logic       animate;
  logic [8:0] solid;
  logic       tvalid;
  logic       tready = 1'b0;
  logic [8:0] tdata;
  logic       tuser;
  logic       tlast;
  logic [7:0] frame_cnt;
  logic       busy;

  always #5 clk = ~clk;

  axis_pattern_generator #(
    .H_RES(H), .V_RES(V), .R_WIDTH(RW), .G_WIDTH(GW), .B_WIDTH(BW), .CHECK_LOG2(CL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .enable_i(enable),
    .mode_i(mode),
    .animate_i(animate),
    .solid_color_i(solid),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tdata(tdata),
    .m_axis_tuser(tuser),
    .m_axis_tlast(tlast),
    .frame_cnt_o(frame_cnt),
    .busy_o(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Configuration the next frame should use; applied by the monitor at each frame's first beat.
  int         nxt_mode  = 0;
  bit         nxt_anim  = 1'b0;
  logic [8:0] nxt_solid = '0;
  bit         rdy_random = 1'b0;
  bit         rdy_level  = 1'b1;

  int         cur_mode;
  bit         cur_anim;
  logic [8:0] cur_solid;
  int         mx, my, frames, beats;
  bit         prev_stall;
  logic [8:0] prev_data;
  logic       prev_user, prev_last;

  function automatic logic [8:0] exp_pixel(int x, int y, int md, bit an, logic [8:0] sc, int fc);
    int r, g, b, s, idx;
    logic [2:0] rgb;
    case (md)
      0: begin
        r = x >> (XW - RW);
        g = y >> (YW - GW);
        s = (x + y + (an ? fc : 0)) % (1 << SW);
        b = s >> (SW - BW);
        return 9'((r << (GW + BW)) | (g << BW) | b);
      end
      1: begin
        idx = x / BAR_W;
        if (idx > 7) idx = 7;
        case (idx)
          0: rgb = 3'b111;
          1: rgb = 3'b110;
          2: rgb = 3'b011;
          3: rgb = 3'b010;
          4: rgb = 3'b101;
          5: rgb = 3'b100;
          6: rgb = 3'b001;
          default: rgb = 3'b000;
        endcase
        r = rgb[2] ? (1 << RW) - 1 : 0;
        g = rgb[1] ? (1 << GW) - 1 : 0;
        b = rgb[0] ? (1 << BW) - 1 : 0;
        return 9'((r << (GW + BW)) | (g << BW) | b);
      end
      2: return (((x >> CL) & 1) == ((y >> CL) & 1)) ? 9'h1FF : 9'h000;
      default: return sc;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    tready = rdy_random ? 1'($urandom_range(0, 1)) : rdy_level;
  end

  always @(negedge clk) begin
    if (rst) begin
      mx = 0; my = 0; frames = 0; beats = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", tvalid, 1);
        if (tvalid) begin
          check("hold_data", tdata, prev_data);
          check("hold_user", tuser, prev_user);
          check("hold_last", tlast, prev_last);
        end
      end
      if (tvalid && tready) begin
        if (mx == 0 && my == 0) begin
          cur_mode = nxt_mode; cur_anim = nxt_anim; cur_solid = nxt_solid;
        end
        check("data", tdata, exp_pixel(mx, my, cur_mode, cur_anim, cur_solid, frames % 256));
        check("user", tuser, (mx == 0 && my == 0));
        check("last", tlast, (mx == H - 1));
        beats++;
        if (mx == H - 1) begin
          mx = 0;
          if (my == V - 1) begin my = 0; frames++; end
          else my++;
        end else mx++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_user  = tuser;
      prev_last  = tlast;
    end
  end

  task automatic wait_beats(input int target, input int budget, input string tag);
    int k = 0;
    while (beats < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_timeout"}, beats >= target, 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while ((busy || tvalid) && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_idle_timeout"}, !(busy || tvalid), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0; animate = 1'b0; solid = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 0);
    check("rst_tlast", tlast, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: solid colour, latency, tuser/tlast placement
    mode = 2'd3; solid = 9'h1A5;
    nxt_mode = 3; nxt_solid = 9'h1A5; nxt_anim = 1'b0;
    enable = 1'b1;
    @(posedge clk); #1;
    check("t1_lat_valid0", tvalid, 0);
    check("t1_busy_up", busy, 1);
    @(posedge clk); #1;
    check("t1_lat_valid1", tvalid, 1);
    check("t1_first_user", tuser, 1);
    repeat (5) @(posedge clk);
    #1 enable = 1'b0;
    wait_beats(FRAME, 500, "t1");
    wait_idle(50, "t1");
    @(posedge clk); #1;
    check("t1_beats", beats, FRAME);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_busy", busy, 0);

    // T2: colour bars
    mode = 2'd1; nxt_mode = 1;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 enable = 1'b0;
    wait_beats(2 * FRAME, 500, "t2");
    wait_idle(50, "t2");
    check("t2_beats", beats, 2 * FRAME);
    check("t2_frame_cnt", frame_cnt, 2);

    // T3: animated gradient under random backpressure, two back-to-back frames
    mode = 2'd0; animate = 1'b1; nxt_mode = 0; nxt_anim = 1'b1;
    rdy_random = 1'b1;
    enable = 1'b1;
    wait_beats(3 * FRAME + 6, 2000, "t3");
    #1 enable = 1'b0;
    wait_idle(2000, "t3");
    check("t3_beats", beats, 4 * FRAME);
    check("t3_frame_cnt", frame_cnt, 4);
    rdy_random = 1'b0;

    // T4: mode change mid-frame takes effect on the next frame only
    do_reset();
    mode = 2'd2; animate = 1'b0; nxt_mode = 2; nxt_anim = 1'b0;
    enable = 1'b1;
    wait_beats(20, 500, "t4a");
    #1 mode = 2'd0; nxt_mode = 0;
    wait_beats(FRAME, 500, "t4b");
    #1;
    check("t4_frame_cnt1", frame_cnt, 1);
    enable = 1'b0;
    wait_beats(2 * FRAME, 500, "t4c");
    wait_idle(50, "t4");
    check("t4_beats", beats, 2 * FRAME);
    check("t4_frame_cnt2", frame_cnt, 2);

    // T5: enable dropped mid-frame, then restart
    mode = 2'd3; solid = 9'($urandom); nxt_mode = 3; nxt_solid = solid;
    enable = 1'b1;
    wait_beats(2 * FRAME + 10, 500, "t5a");
    #1 enable = 1'b0;
    wait_idle(500, "t5");
    @(posedge clk); #1;
    check("t5_beats", beats, 3 * FRAME);
    check("t5_tvalid", tvalid, 0);
    check("t5_busy", busy, 0);
    check("t5_frame_cnt", frame_cnt, 3);
    solid = 9'($urandom); nxt_solid = solid;
    enable = 1'b1;
    wait_beats(3 * FRAME + 1, 50, "t5b");
    #1 enable = 1'b0;
    wait_idle(500, "t5b");
    check("t5_restart_beats", beats, 4 * FRAME);

    // T6: asynchronous reset while stalled mid-frame
    mode = 2'd2; nxt_mode = 2;
    rdy_random = 1'b1;
    enable = 1'b1;
    wait_beats(4 * FRAME + 30, 1000, "t6a");
    rdy_random = 1'b0; rdy_level = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_tvalid", tvalid, 0);
    check("t6_tdata", tdata, 0);
    check("t6_tuser", tuser, 0);
    check("t6_tlast", tlast, 0);
    check("t6_frame_cnt", frame_cnt, 0);
    check("t6_busy", busy, 0);
    enable = 1'b0;
    mode = 2'd0; animate = 1'b1; nxt_mode = 0; nxt_anim = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rdy_level = 1'b1;
    enable = 1'b1;
    wait_beats(1, 50, "t6b");
    #1 enable = 1'b0;
    wait_beats(FRAME, 500, "t6c");
    wait_idle(50, "t6");
    check("t6_beats", beats, FRAME);
    check("t6_frame_cnt1", frame_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
